instr_encode_loader: RTL and testbench

Sequential instruction encoder and program loader: accepts decoded instruction fields over a valid/ready stream, packs each into the 32-bit processor instruction word, and writes the words to consecutive instruction-memory locations. It is the packing counterpart of the processor's field decoder. It sits between the test/boot host (or a UART command parser) and the instruction memory write port, and signals when a program image is complete.

---
 rtl/instr_encode_loader.sv | 138 +++++++++++++
 tb/tb_instr_encode_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// Instruction encoder and program loader: packs decoded instruction fields into
// 32-bit words and writes them to consecutive instruction-memory locations.
module instr_encode_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            fmt,
  input  logic [4:0]            opcode,
  input  logic [3:0]            rd,
  input  logic [3:0]            rs1,
  input  logic [3:0]            rs2,
  input  logic [17:0]           imm18,
  input  logic [26:0]           offset,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  done,
  output logic                  err_illegal
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LAST_C  = DEPTH_C - 1'b1;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_B   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_acc_cnt;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_err_illegal;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_illegal;
  logic                  w_enter_load;
  logic [31:0]           w_encoded;

  function automatic logic [31:0] encode(
    input logic [1:0]  f,
    input logic [4:0]  op,
    input logic [3:0]  r_d,
    input logic [3:0]  r_s1,
    input logic [3:0]  r_s2,
    input logic [17:0] imm,
    input logic [26:0] off
  );
    logic [31:0] word;
    word = 32'h0;
    case (f)
      FMT_R:   word = {op, 1'b0, r_d, r_s1, r_s2, 14'b0};
      FMT_I:   word = {op, 1'b1, r_d, r_s1, imm};
      FMT_B:   word = {op, off};
      default: word = 32'h0;
    endcase
    return word;
  endfunction

  assign w_ready      = (r_state == S_LOAD) && (r_acc_cnt < DEPTH_C);
  assign w_accept     = in_valid && w_ready;
  assign w_legal      = w_accept && (fmt != 2'b11);
  assign w_illegal    = w_accept && (fmt == 2'b11);
  assign w_enter_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_encoded    = encode(fmt, opcode, rd, rs1, rs2, imm18, offset);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      // The accept that fills the last location closes the session on its own.
      S_LOAD:  if (finish || (w_legal && (r_acc_cnt == LAST_C))) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mem_we      <= 1'b0;
      r_err_illegal <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_state       <= w_next;
      r_mem_we      <= w_legal;
      r_err_illegal <= w_illegal;
      if (w_legal) begin
        r_mem_addr  <= r_acc_cnt[ADDR_WIDTH-1:0];
        r_mem_wdata <= w_encoded;
      end
    end
  end

  // Counters restart on every LOAD entry; a write strobe is never pending then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_cnt    <= '0;
      r_word_count <= '0;
    end else if (w_enter_load) begin
      r_acc_cnt    <= '0;
      r_word_count <= '0;
    end else begin
      if (w_legal)  r_acc_cnt    <= r_acc_cnt + 1'b1;
      if (r_mem_we) r_word_count <= r_word_count + 1'b1;
    end
  end

  assign in_ready    = w_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign word_count  = r_word_count;
  assign full        = (r_word_count == DEPTH_C);
  assign done        = (r_state == S_DONE);
  assign err_illegal = r_err_illegal;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed scenarios then random traffic, all
// checked cycle by cycle against a session-level reference model.
module tb_instr_encode_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, finish, in_valid;
  logic [1:0]    fmt;
  logic [4:0]    opcode;
  logic [3:0]    rd, rs1, rs2;
  logic [17:0]   imm18;
  logic [26:0]   offset;
  logic          in_ready, mem_we, full, done, err_illegal;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: session flags, accepted count, written count, last write.
  bit          m_loading, m_draining, m_done, m_we, m_err;
  int          m_n, m_wc;
  int unsigned m_addr, m_wdata;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm18(imm18), .offset(offset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .full(full), .done(done),
    .err_illegal(err_illegal)
  );

  function automatic int unsigned enc_ref();
    int unsigned w;
    w = opcode * 32'd134217728;
    if (fmt == 2'd0) w = w + rd * 32'd4194304 + rs1 * 32'd262144 + rs2 * 32'd16384;
    else if (fmt == 2'd1) w = w + 32'd67108864 + rd * 32'd4194304 + rs1 * 32'd262144 + imm18;
    else w = w + offset;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit acc, legal, was_draining;
    chk("in_ready", 32'(in_ready), 32'(m_loading && (m_n < DEPTH)));
    if (!rst_n) begin
      m_loading = 0; m_draining = 0; m_done = 0; m_we = 0; m_err = 0;
      m_n = 0; m_wc = 0; m_addr = 0; m_wdata = 0;
    end else begin
      was_draining = m_draining;
      acc   = in_valid && m_loading && (m_n < DEPTH);
      legal = acc && (fmt != 2'd3);
      if (m_we) m_wc++;
      if (m_draining) begin m_draining = 0; m_done = 1; end
      m_err = acc && (fmt == 2'd3);
      m_we  = legal;
      if (legal) begin m_addr = m_n; m_wdata = enc_ref(); m_n++; end
      if (m_loading && (finish || (legal && m_n == DEPTH))) begin
        m_loading = 0; m_draining = 1;
      end else if (start && !m_loading && !was_draining) begin
        m_loading = 1; m_n = 0; m_wc = 0; m_done = 0;
      end
    end
    @(posedge clk); #1;
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("err_illegal", 32'(err_illegal), 32'(m_err));
    chk("word_count", 32'(word_count), 32'(m_wc));
    chk("full", 32'(full), 32'(m_wc == DEPTH));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic beat(input logic [1:0] f, input logic [4:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] c, input logic [17:0] imm,
                      input logic [26:0] off);
    in_valid = 1; fmt = f; opcode = op; rd = a; rs1 = b; rs2 = c; imm18 = imm; offset = off;
  endtask

  task automatic rand_beat(input int fmax);
    beat(2'($urandom_range(0, fmax)), 5'($urandom), 4'($urandom), 4'($urandom),
         4'($urandom), 18'($urandom), 27'($urandom));
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic pulse_finish();
    finish = 1; step(); finish = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; finish = 0; in_valid = 0;
    fmt = 0; opcode = 0; rd = 0; rs1 = 0; rs2 = 0; imm18 = 0; offset = 0;
    m_loading = 0; m_draining = 0; m_done = 0; m_we = 0; m_err = 0;
    m_n = 0; m_wc = 0; m_addr = 0; m_wdata = 0;
    @(posedge clk); #1;
    step(); step();
    chk("reset_wc", 32'(word_count), 32'd0);
    rst_n = 1; step();

    // R-type word
    pulse_start();
    beat(2'd0, 5'h03, 4'd2, 4'd5, 4'd7, 18'h0, 27'h0); step();
    chk("r_we", 32'(mem_we), 32'd1);
    chk("r_word", mem_wdata, 32'h1895C000);
    chk("r_addr", 32'(mem_addr), 32'd0);
    in_valid = 0; step();
    chk("r_wc", 32'(word_count), 32'd1);
    pulse_finish(); step(); step();

    // I-type then B-type back to back
    pulse_start();
    beat(2'd1, 5'h01, 4'd1, 4'd0, 4'd9, 18'h3FFFF, 27'h5); step();
    chk("i_word", mem_wdata, 32'h0C43FFFF);
    chk("i_addr", 32'(mem_addr), 32'd0);
    beat(2'd2, 5'h10, 4'd3, 4'd3, 4'd3, 18'h123, 27'hABC); step();
    chk("b_we", 32'(mem_we), 32'd1);
    chk("b_word", mem_wdata, 32'h80000ABC);
    chk("b_addr", 32'(mem_addr), 32'd1);
    in_valid = 0; pulse_finish(); step(); step();

    // Illegal beat between two legal ones
    pulse_start();
    rand_beat(2); step();
    beat(2'd3, 5'h1F, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 27'h7FFFFFF); step();
    chk("ill_pulse", 32'(err_illegal), 32'd1);
    chk("ill_nowe", 32'(mem_we), 32'd0);
    rand_beat(2); step();
    chk("ill_addr", 32'(mem_addr), 32'd1);
    chk("ill_err_off", 32'(err_illegal), 32'd0);
    in_valid = 0; step();
    chk("ill_wc", 32'(word_count), 32'd2);
    pulse_finish(); step(); step();

    // Fill all locations with in_valid held for six beats
    pulse_start();
    for (int i = 0; i < 6; i++) begin rand_beat(2); step(); end
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_wc", 32'(word_count), 32'd4);
    chk("fill_done", 32'(done), 32'd1);
    in_valid = 0; step();

    // finish coincident with the third accept
    pulse_start();
    rand_beat(2); step();
    rand_beat(2); step();
    rand_beat(2); finish = 1; step(); finish = 0; in_valid = 0;
    chk("fin_we", 32'(mem_we), 32'd1);
    chk("fin_addr", 32'(mem_addr), 32'd2);
    chk("fin_done_early", 32'(done), 32'd0);
    step();
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_wc", 32'(word_count), 32'd3);
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_wc", 32'(word_count), 32'd0);
    rand_beat(2); step();
    chk("restart_addr", 32'(mem_addr), 32'd0);

    // Reset right after an accept
    rand_beat(2); step();
    in_valid = 0; rst_n = 0; step();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1; step(); step();
    chk("rst_ready", 32'(in_ready), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 79) != 0);
      start  = ($urandom_range(0, 9) == 0);
      finish = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) != 0) rand_beat(3);
      else in_valid = 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
